// File: rtl/btn_debounce_pkg.sv
// Project constants shared by the button front-end blocks.
package btn_debounce_pkg;

  localparam int DEBOUNCE_CNT_DFLT = 21;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// The reset clears both stages to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic q1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronize, then accept a new level after 2^N consecutive differing samples.
// Emits a one-cycle raise pulse only on an accepted press.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic raise
);

  localparam logic [DEBOUNCE_CNT-1:0] CNT_MAX = '1;
  localparam logic [DEBOUNCE_CNT-1:0] CNT_ONE = DEBOUNCE_CNT'(1);

  logic                    sync_q2;
  logic                    stable;
  logic [DEBOUNCE_CNT-1:0] cnt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (sync_q2)
  );

  // The count saturates at CNT_MAX only long enough to commit the new level; it never wraps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stable <= 1'b0;
      cnt    <= '0;
      raise  <= 1'b0;
    end else begin
      raise <= 1'b0;
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end else begin
        stable <= sync_q2;
        cnt    <= '0;
        raise  <= sync_q2;
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed press/bounce/reset scenarios plus random
// button traffic, compared each cycle against a run-length reference model.
module tb_btn_debounce;

  localparam int N    = 3;
  localparam int FILT = 1 << N;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn = 1'b0;
  logic raise;

  btn_debounce #(.DEBOUNCE_CNT(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .raise (raise)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: button level seen two edges late, accepted after FILT consecutive differing edges.
  bit hist[$];
  bit m_stable;
  int m_run;
  bit m_raise;

  int edge_no    = 0;
  int pulse_cnt  = 0;
  int last_pulse = 0;
  int mark       = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  task automatic model_edge(input bit b, input bit r);
    bit d;
    m_raise = 1'b0;
    if (!r) begin
      hist     = {1'b0, 1'b0};
      m_stable = 1'b0;
      m_run    = 0;
    end else begin
      d = hist.pop_front();
      hist.push_back(b);
      if (d != m_stable) begin
        m_run++;
        if (m_run == FILT) begin
          m_stable = d;
          m_run    = 0;
          m_raise  = d;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic step(input bit b, input bit r);
    @(negedge clk);
    btn = b;
    rst = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
    edge_no++;
    chk("raise_vs_model", raise, m_raise);
    if (raise === 1'b1) begin
      pulse_cnt++;
      last_pulse = edge_no;
    end
  endtask

  task automatic seg(input bit b, input int n, input bit r);
    for (int i = 0; i < n; i++) step(b, r);
  endtask

  initial begin
    bit rb;
    bit rr;
    int rl;

    hist     = {1'b0, 1'b0};
    m_stable = 1'b0;
    m_run    = 0;
    m_raise  = 1'b0;

    // Reset held with the button pressed, then released into a held press.
    pulse_cnt = 0;
    seg(1'b1, 6, 1'b0);
    chk("reset_hold_pulses", pulse_cnt, 0);
    mark = edge_no + 1;
    step(1'b1, 1'b1);
    chk("first_edge_after_rst", raise, 0);
    seg(1'b1, 29, 1'b1);
    chk("held_at_reset_pulses", pulse_cnt, 1);
    chk("held_at_reset_latency", last_pulse - mark, 9);

    pulse_cnt = 0;
    seg(1'b0, 20, 1'b1);
    chk("release_no_pulse", pulse_cnt, 0);

    // Clean press.
    pulse_cnt = 0;
    mark = edge_no + 1;
    seg(1'b1, 30, 1'b1);
    chk("clean_press_pulses", pulse_cnt, 1);
    chk("clean_press_latency", last_pulse - mark, 9);
    seg(1'b0, 20, 1'b1);

    // Bouncy press.
    pulse_cnt = 0;
    seg(1'b1, 5, 1'b1);
    seg(1'b0, 2, 1'b1);
    mark = edge_no + 1;
    seg(1'b1, 30, 1'b1);
    chk("bounce_pulses", pulse_cnt, 1);
    chk("bounce_latency", last_pulse - mark, 9);
    seg(1'b0, 20, 1'b1);

    // Glitch one edge short of acceptance.
    pulse_cnt = 0;
    seg(1'b1, 7, 1'b1);
    seg(1'b0, 20, 1'b1);
    chk("short_glitch_pulses", pulse_cnt, 0);

    // Re-press after a release.
    pulse_cnt = 0;
    mark = edge_no + 1;
    seg(1'b1, 20, 1'b1);
    chk("repress_pulses", pulse_cnt, 1);
    chk("repress_latency", last_pulse - mark, 9);
    seg(1'b0, 20, 1'b1);

    // Reset in the middle of a count.
    pulse_cnt = 0;
    seg(1'b1, 5, 1'b1);
    seg(1'b1, 2, 1'b0);
    chk("midcount_rst_no_pulse", pulse_cnt, 0);
    mark = edge_no + 1;
    seg(1'b1, 20, 1'b1);
    chk("midcount_rst_pulses", pulse_cnt, 1);
    chk("midcount_rst_latency", last_pulse - mark, 9);
    seg(1'b0, 20, 1'b1);

    // Random traffic with occasional resets.
    for (int k = 0; k < 80; k++) begin
      rb = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 19) != 0);
      rl = rr ? int'($urandom_range(1, 14)) : int'($urandom_range(1, 3));
      seg(rb, rl, rr);
    end
    seg(1'b0, 20, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
